// File: rtl/tmds_pkg.sv
// TMDS encoder shared definitions: symbol width, control tokens,
// stage bundles and the popcount helper.
package tmds_pkg;

   localparam int SYM_W = 10;

   localparam logic [SYM_W-1:0] TOKEN_C00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] TOKEN_C01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] TOKEN_C10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] TOKEN_C11 = 10'b1010101011;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] c;
      logic       blank;
   } tmds_in_t;

   typedef struct packed {
      logic [8:0] q_m;
      logic [1:0] c;
      logic       blank;
   } tmds_qm_t;

   localparam tmds_in_t IN_RST = '{
      data:  8'h00,
      c:     2'b00,
      blank: 1'b1
   };

   localparam tmds_qm_t QM_RST = '{
      q_m:   9'h000,
      c:     2'b00,
      blank: 1'b1
   };

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
      logic [SYM_W-1:0] t;
      unique case (c)
         2'b00:   t = TOKEN_C00;
         2'b01:   t = TOKEN_C01;
         2'b10:   t = TOKEN_C10;
         default: t = TOKEN_C11;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising stage: 8-bit data to 9-bit q_m, where q_m[8]
// records whether the XOR (1) or XNOR (0) chain was used.
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic [7:0] data,
   output logic [8:0] q_m
);

   logic [3:0] n1d;
   logic       use_xnor;
   logic [8:0] q;

   always_comb begin
      n1d      = popcount8(data);
      use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
      q        = 9'h000;
      q[0]     = data[0];
      for (int i = 1; i < 8; i++) begin
         if (use_xnor) begin
            q[i] = ~(q[i-1] ^ data[i]);
         end else begin
            q[i] = q[i-1] ^ data[i];
         end
      end
      q[8] = ~use_xnor;
   end

   assign q_m = q;

endmodule

// File: rtl/tmds_encoder_dc.sv
// Single-channel TMDS encoder with running-disparity tracking.
// Latency is 1 + c_pipeline enabled pixel clocks.
module tmds_encoder_dc
   import tmds_pkg::*;
#(
   parameter int c_pipeline = 1,
   parameter int c_cnt_bits = 5
) (
   input  logic                         clk_pixel,
   input  logic                         resetn,
   input  logic                         clk_pixel_ena,
   input  logic [7:0]                   in_data,
   input  logic [1:0]                   in_c,
   input  logic                         in_blank,
   output logic [SYM_W-1:0]             out_symbol,
   output logic signed [c_cnt_bits-1:0] out_disparity
);

   localparam int CW = c_cnt_bits;

   tmds_in_t in_r;
   tmds_qm_t s1;
   tmds_qm_t s2;
   logic [8:0] q_m;

   always_ff @(posedge clk_pixel) begin
      if (!resetn) begin
         in_r <= IN_RST;
      end else if (clk_pixel_ena) begin
         in_r <= '{data: in_data, c: in_c, blank: in_blank};
      end
   end

   tmds_qm_stage u_qm (
      .data (in_r.data),
      .q_m  (q_m)
   );

   assign s1 = '{q_m: q_m, c: in_r.c, blank: in_r.blank};

   generate
      if (c_pipeline != 0) begin : g_pipe
         tmds_qm_t s_r;
         always_ff @(posedge clk_pixel) begin
            if (!resetn) begin
               s_r <= QM_RST;
            end else if (clk_pixel_ena) begin
               s_r <= s1;
            end
         end
         assign s2 = s_r;
      end else begin : g_comb
         assign s2 = s1;
      end
   endgenerate

   logic signed [CW-1:0] cnt;
   logic signed [CW-1:0] cnt_nx;
   logic signed [CW-1:0] n1;
   logic signed [CW-1:0] n0;
   logic signed [CW-1:0] d10;
   logic signed [CW-1:0] d01;
   logic signed [CW-1:0] two_q8;
   logic signed [CW-1:0] two_nq8;
   logic [SYM_W-1:0]     sym_nx;
   logic [3:0]           ones;
   logic [7:0]           qv;
   logic                 q8;
   logic                 cnt_pos;
   logic                 cnt_neg;
   logic                 case_a;
   logic                 case_b;

   always_comb begin
      qv      = s2.q_m[7:0];
      q8      = s2.q_m[8];
      ones    = popcount8(qv);
      n1      = CW'(ones);
      n0      = CW'(4'd8 - ones);
      d10     = n1 - n0;
      d01     = n0 - n1;
      two_q8  = q8 ? CW'(2) : '0;
      two_nq8 = q8 ? '0 : CW'(2);
      cnt_neg = cnt[CW-1];
      cnt_pos = !cnt[CW-1] && (cnt != '0);
      case_a  = (cnt == '0) || (n1 == n0);
      case_b  = (cnt_pos && (n1 > n0)) || (cnt_neg && (n0 > n1));
      sym_nx  = TOKEN_C00;
      cnt_nx  = cnt;
      if (s2.blank) begin
         sym_nx = ctrl_token(s2.c);
         cnt_nx = '0;
      end else begin
         // case_b can only hold when cnt != 0 and n1 != n0
         unique case (1'b1)
            case_a: begin
               sym_nx = {~q8, q8, q8 ? qv : ~qv};
               cnt_nx = cnt + (q8 ? d10 : d01);
            end
            case_b: begin
               sym_nx = {1'b1, q8, ~qv};
               cnt_nx = cnt + two_q8 + d01;
            end
            default: begin
               sym_nx = {1'b0, q8, qv};
               cnt_nx = cnt + d10 - two_nq8;
            end
         endcase
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (!resetn) begin
         out_symbol <= TOKEN_C00;
         cnt        <= '0;
      end else if (clk_pixel_ena) begin
         out_symbol <= sym_nx;
         cnt        <= cnt_nx;
      end
   end

   assign out_disparity = cnt;

endmodule

// File: tb/tb_tmds_encoder_dc.sv
// Scoreboard bench for tmds_encoder_dc, both pipeline depths side by side.
// Expected symbols come from a behavioural TMDS model and a decoder.
module tb_tmds_encoder_dc;

   logic              clk_pixel = 1'b0;
   logic              resetn = 1'b0;
   logic              clk_pixel_ena = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic [1:0]        in_c = 2'b00;
   logic              in_blank = 1'b1;
   logic [9:0]        sym0;
   logic [9:0]        sym1;
   logic signed [4:0] disp0;
   logic signed [4:0] disp1;

   always #5 clk_pixel = ~clk_pixel;

   tmds_encoder_dc #(.c_pipeline(0), .c_cnt_bits(5)) u_dut0 (
      .clk_pixel     (clk_pixel),
      .resetn        (resetn),
      .clk_pixel_ena (clk_pixel_ena),
      .in_data       (in_data),
      .in_c          (in_c),
      .in_blank      (in_blank),
      .out_symbol    (sym0),
      .out_disparity (disp0)
   );

   tmds_encoder_dc #(.c_pipeline(1), .c_cnt_bits(5)) u_dut1 (
      .clk_pixel     (clk_pixel),
      .resetn        (resetn),
      .clk_pixel_ena (clk_pixel_ena),
      .in_data       (in_data),
      .in_c          (in_c),
      .in_blank      (in_blank),
      .out_symbol    (sym1),
      .out_disparity (disp1)
   );

   typedef struct {
      logic [9:0] sym;
      int         disp;
      logic       blank;
      logic [1:0] c;
      logic [7:0] data;
      logic       pin;
      logic [9:0] psym;
      int         pdisp;
   } ent_t;

   ent_t q0[$];
   ent_t q1[$];
   ent_t last0;
   ent_t last1;
   int   mcnt;
   int   n_assert = 0;
   int   n_fail = 0;

   function automatic logic [9:0] tok(input logic [1:0] c);
      case (c)
         2'd0:    return 10'h354;
         2'd1:    return 10'h0AB;
         2'd2:    return 10'h154;
         default: return 10'h2AB;
      endcase
   endfunction

   function automatic logic [8:0] ref_qm(input logic [7:0] d);
      logic [8:0] q;
      int         n;
      logic       xn;
      n    = $countones(d);
      xn   = (n > 4) || (n == 4 && d[0] == 1'b0);
      q    = 9'h000;
      q[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = !xn;
      return q;
   endfunction

   function automatic logic [7:0] dec_data(input logic [9:0] s);
      logic [7:0] v;
      logic [7:0] d;
      v    = s[9] ? ~s[7:0] : s[7:0];
      d    = 8'h00;
      d[0] = v[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
      end
      return d;
   endfunction

   function automatic logic [3:0] dec_c(input logic [9:0] s);
      case (s)
         10'h354: return 4'd0;
         10'h0AB: return 4'd1;
         10'h154: return 4'd2;
         10'h2AB: return 4'd3;
         default: return 4'hF;
      endcase
   endfunction

   task automatic chk(input string tag, input int k,
                      input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_push(input logic [7:0] d, input logic [1:0] c,
                             input logic b, input logic pin,
                             input logic [9:0] psym, input int pdisp);
      ent_t       e;
      logic [8:0] qm;
      int         n1;
      int         n0;
      e.blank = b;
      e.c     = c;
      e.data  = d;
      e.pin   = pin;
      e.psym  = psym;
      e.pdisp = pdisp;
      if (b) begin
         e.sym = tok(c);
         mcnt  = 0;
      end else begin
         qm = ref_qm(d);
         n1 = $countones(qm[7:0]);
         n0 = 8 - n1;
         if (mcnt == 0 || n1 == n0) begin
            e.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt  = mcnt + (qm[8] ? (n1 - n0) : (n0 - n1));
         end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            e.sym = {1'b1, qm[8], ~qm[7:0]};
            mcnt  = mcnt + 2 * int'(qm[8]) + n0 - n1;
         end else begin
            e.sym = {1'b0, qm[8], qm[7:0]};
            mcnt  = mcnt + n1 - n0 - 2 * int'(!qm[8]);
         end
      end
      e.disp = mcnt;
      q0.push_back(e);
      q1.push_back(e);
   endtask

   task automatic check_one(input int k, input logic [9:0] s,
                            input int dsp, input ent_t e);
      chk("sym", k, 32'(s), 32'(e.sym));
      chk("disp", k, dsp, e.disp);
      chk("bound", k, 32'(dsp >= -10 && dsp <= 10), 32'd1);
      if (e.blank) begin
         chk("dec_c", k, 32'(dec_c(s)), 32'(e.c));
      end else begin
         chk("dec_data", k, 32'(dec_data(s)), 32'(e.data));
      end
      if (e.pin) begin
         chk("pin_sym", k, 32'(s), 32'(e.psym));
         chk("pin_disp", k, dsp, e.pdisp);
      end
   endtask

   task automatic post_edge(input logic ena);
      if (ena) begin
         last0 = q0.pop_front();
         last1 = q1.pop_front();
      end
      check_one(0, sym0, int'(disp0), last0);
      check_one(1, sym1, int'(disp1), last1);
   endtask

   task automatic step(input logic [7:0] d, input logic [1:0] c,
                       input logic b, input logic ena,
                       input logic pin = 1'b0,
                       input logic [9:0] psym = 10'h000,
                       input int pdisp = 0);
      @(negedge clk_pixel);
      resetn        = 1'b1;
      in_data       = d;
      in_c          = c;
      in_blank      = b;
      clk_pixel_ena = ena;
      @(posedge clk_pixel);
      if (ena) begin
         model_push(d, c, b, pin, psym, pdisp);
      end
      #1;
      post_edge(ena);
   endtask

   task automatic do_reset(input logic ena);
      ent_t pf;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_pixel);
         resetn        = 1'b0;
         clk_pixel_ena = ena;
         in_data       = 8'($urandom);
         in_c          = 2'($urandom);
         in_blank      = 1'($urandom);
         @(posedge clk_pixel);
         #1;
         chk("rst_sym", 0, 32'(sym0), 32'h354);
         chk("rst_disp", 0, int'(disp0), 0);
         chk("rst_sym", 1, 32'(sym1), 32'h354);
         chk("rst_disp", 1, int'(disp1), 0);
      end
      mcnt     = 0;
      pf.sym   = 10'h354;
      pf.disp  = 0;
      pf.blank = 1'b1;
      pf.c     = 2'b00;
      pf.data  = 8'h00;
      pf.pin   = 1'b0;
      pf.psym  = 10'h000;
      pf.pdisp = 0;
      q0.delete();
      q1.delete();
      q0.push_back(pf);
      q1.push_back(pf);
      q1.push_back(pf);
      last0 = pf;
      last1 = pf;
   endtask

   initial begin
      int  burst;
      logic b;
      logic [1:0] c;

      do_reset(1'b1);
      do_reset(1'b0);

      step(8'h5A, 2'b00, 1'b1, 1'b1, 1'b1, 10'h354, 0);
      step(8'hA5, 2'b01, 1'b1, 1'b1, 1'b1, 10'h0AB, 0);
      step(8'h3C, 2'b10, 1'b1, 1'b1, 1'b1, 10'h154, 0);
      step(8'hC3, 2'b11, 1'b1, 1'b1, 1'b1, 10'h2AB, 0);
      step(8'h00, 2'b00, 1'b1, 1'b1);

      step(8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 10'h100, -8);
      step(8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 10'h3FF, 2);
      step(8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 10'h100, -6);
      for (int i = 0; i < 13; i++) begin
         step(8'h00, 2'b00, 1'b0, 1'b1);
      end

      step(8'h00, 2'b00, 1'b1, 1'b1);
      step(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 10'h200, -8);
      step(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 10'h0FF, -2);
      step(8'h10, 2'b00, 1'b0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         step(8'($urandom), 2'b00, 1'b0, 1'(i % 4 == 0 || i % 4 == 3));
      end

      burst = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset(1'($urandom));
         end
         if (burst > 0) begin
            burst--;
            b = 1'b1;
         end else if ($urandom_range(0, 39) == 0) begin
            burst = $urandom_range(1, 12);
            b = 1'b1;
         end else begin
            b = 1'b0;
         end
         c = b ? 2'($urandom) : 2'b00;
         step(8'($urandom), c, b, 1'($urandom_range(0, 7) != 0));
      end

      for (int i = 0; i < 3; i++) begin
         step(8'h00, 2'b00, 1'b1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
